pwm_capture_apb: RTL
====================

// Module: pwm_capture_apb
// PURPOSE
//  Multi-channel PWM pulse-width capture peripheral on the APB3 bus; successor to the single-channel distance-sensor interface.
//  Measures the high time of each sensor_pwm input in PCLK cycles.
//  Flags new samples, counter saturation and dead sensors; raises a level interrupt.
//  Sits beside the other sensor peripherals on the fabric APB3 slave bus.
// PARAMETERS
//  NUM_CH   4        number of capture channels (1..8)
//  CNT_W    24       width counter bits (8..32); results zero-extended to 32
//  TIMEOUT  5000000  PCLK cycles with no completed pulse before STALE sets (50 ms @ 100 MHz)
// PORTS
//  PCLK        in   1       clock
//  PRESERN     in   1       asynchronous active-low reset
//  PSEL        in   1       APB select
//  PENABLE     in   1       APB access phase
//  PWRITE      in   1       APB write
//  PADDR       in   32      APB address; PADDR[7:0] decoded
//  PWDATA      in   32      APB write data
//  PRDATA      out  32      APB read data
//  PREADY      out  1       tied 1 (zero wait states)
//  PSLVERR     out  1       tied 0
//  sensor_pwm  in   NUM_CH  asynchronous PWM inputs
//  irq         out  1       level interrupt = |(NEW & IRQ_EN)
// BEHAVIOUR
//  Reset: all WIDTH/AVG = 0; NEW/OVF/STALE = 0; CTRL.EN = all 1; IRQ_EN = 0; irq = 0; channel FSMs in ARM.
//  Input path: 2-FF synchroniser per channel; edges detected on synced signal.
//  Per-channel FSM (EN=0 forces ARM and clears the counter):
//   ARM  -> wait for synced low, then IDLE. Pulses already high at reset/enable are never measured.
//   IDLE -> rising edge: cnt=1, go HIGH.
//   HIGH -> while high: cnt+1, saturating at 2^CNT_W-1.
//        -> saturation: OVF sticky set.
//        -> falling edge: WIDTH<=cnt, NEW set, STALE cleared, timeout counter cleared; go IDLE.
//  Latency: WIDTH readable 3 PCLK after the raw input falls.
//   WIDTH equals the number of cycles the synced input was high.
//  Timeout: per-channel counter, cleared on each latch, saturates at TIMEOUT.
//   Reaching TIMEOUT sets STALE. STALE clears only on the next latch.
//  Register map (byte offsets):
//   0x00+4*ch WIDTH[ch]   RO
//   0x20+4*ch AVG[ch]     RO
//   0x40 STATUS: [7:0] NEW, [15:8] OVF, [23:16] STALE
//        Bits 7:0 and 15:8 are W1C; bits 23:16 are RO.
//   0x44 CTRL[7:0] EN (RW)
//   0x48 IRQ_EN[7:0] (RW)
//   Unmapped offsets and channel bits >= NUM_CH read 0; writes to them are ignored.
//  Read: PRDATA is combinational from PADDR while PSEL & !PWRITE; otherwise 0.
//  Write: takes effect on the PCLK edge with PSEL & PENABLE & PWRITE.
//  Simultaneous event: a hardware set (latch/saturate) in the same cycle as a W1C leaves the bit set.
//  Reset mid-pulse: FSM returns to ARM asynchronously; the partial count is discarded.
// CONFIGURATION
//  PWM_AVG_EN defined: per-channel 4-deep history of latched widths.
//   AVG[ch] = sum of last 4 >> 2, with a CNT_W+2 bit sum. Updates 1 cycle after WIDTH.
//   History is zero-filled at reset, so the first three averages include zeros.
//  PWM_AVG_EN undefined: no history logic; AVG registers read 0.
// TESTING
//  ch0 high 100 cycles, IRQ_EN=1 -> WIDTH0=100, STATUS[0]=1, irq=1; W1C 0x1 -> STATUS[0]=0, irq=0.
//  ch1 high when PRESERN releases, falls at +40, then 50-cycle pulse -> first pulse ignored, WIDTH1=50.
//  CNT_W=8, ch2 high 300 cycles -> WIDTH2=255, STATUS[10]=1 (OVF), NEW[2]=1.
//  TIMEOUT=1000, ch3 idle 1000 cycles -> STATUS[19]=1; next 20-cycle pulse -> WIDTH3=20, STATUS[19]=0.
//  W1C of NEW[0] in the same cycle as ch0 latch -> STATUS[0] remains 1.
//  PWM_AVG_EN, ch0 pulses 10,20,30,40 -> AVG0=25; macro undefined -> 0x20 reads 0.

Source files
------------

// File: rtl/pwm_capture_apb.sv
// pwm_capture_apb: multi-channel PWM high-time capture on an APB3 slave port.
// Each channel synchronises its sensor input, measures the high time in PCLK
// cycles and raises NEW/OVF/STALE flags; irq = |(NEW & IRQ_EN).
// Optional macro PWM_AVG_EN adds a per-channel 4-deep width history and AVG registers.

module pwm_capture_apb #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 5000000
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NUM_CH-1:0] sensor_pwm,
  output logic              irq
);

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TO_W-1:0]  TO_FULL = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  logic [NUM_CH-1:0] r_en, r_irq_en, r_new, r_ovf, r_stale;
  logic [NUM_CH-1:0] w_en_nxt, w_irq_en_nxt, w_new_nxt, w_ovf_nxt, w_stale_nxt;
  logic [NUM_CH-1:0] w_latch_v, w_sat_v, w_stale_set_v;
  logic [CNT_W-1:0]  w_width [NUM_CH];
  logic [CNT_W-1:0]  w_avg   [NUM_CH];
  logic [31:0]       w_width_rd [8];
  logic [31:0]       w_avg_rd   [8];
  logic              r_irq;
  logic              w_wr, w_wr_status, w_wr_ctrl, w_wr_irq_en;
  logic              w_unused;

  assign PREADY   = 1'b1;
  assign PSLVERR  = 1'b0;
  assign irq      = r_irq;
  assign w_unused = &{1'b0, PADDR[31:8], PWDATA};

  assign w_wr        = PSEL & PENABLE & PWRITE;
  assign w_wr_status = w_wr & (PADDR[7:0] == 8'h40);
  assign w_wr_ctrl   = w_wr & (PADDR[7:0] == 8'h44);
  assign w_wr_irq_en = w_wr & (PADDR[7:0] == 8'h48);

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic             r_s1, r_s2, r_s3;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, r_width;
    logic [TO_W-1:0]  r_to;
    logic             w_rise, w_fall, w_start, w_inc, w_latch, w_sat;

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    // Synchroniser plus edge-detect delay; resets high so a pulse already
    // present at reset release is seen as "high" and left to the ARM state.
    always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
        r_s1 <= 1'b1;
        r_s2 <= 1'b1;
        r_s3 <= 1'b1;
      end else begin
        r_s1 <= sensor_pwm[gi];
        r_s2 <= r_s1;
        r_s3 <= r_s2;
      end
    end

    // Channel state register.
    always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) r_state <= ST_ARM;
      else          r_state <= w_state_nxt;
    end

    // Next-state logic; a disabled channel is held in ARM.
    always_comb begin
      w_state_nxt = r_state;
      if (!r_en[gi]) begin
        w_state_nxt = ST_ARM;
      end else begin
        case (r_state)
          ST_ARM:  w_state_nxt = r_s2 ? ST_ARM  : ST_IDLE;
          ST_IDLE: w_state_nxt = w_rise ? ST_HIGH : ST_IDLE;
          ST_HIGH: w_state_nxt = w_fall ? ST_IDLE : ST_HIGH;
          default: w_state_nxt = ST_ARM;
        endcase
      end
    end

    // Per-state action strobes for the counter and flags.
    always_comb begin
      w_start = 1'b0;
      w_inc   = 1'b0;
      w_latch = 1'b0;
      w_sat   = 1'b0;
      if (r_en[gi]) begin
        case (r_state)
          ST_IDLE: w_start = w_rise;
          ST_HIGH: begin
            if (w_fall)                 w_latch = 1'b1;
            else if (r_cnt == CNT_MAX)  w_sat   = 1'b1;
            else                        w_inc   = 1'b1;
          end
          default: w_start = 1'b0;
        endcase
      end else begin
        w_start = 1'b0;
      end
    end

    // High-time counter: starts at 1 on the rising edge, saturates at max.
    always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN)       r_cnt <= {CNT_W{1'b0}};
      else if (!r_en[gi]) r_cnt <= {CNT_W{1'b0}};
      else if (w_start)   r_cnt <= CNT_W'(1);
      else if (w_inc)     r_cnt <= r_cnt + CNT_W'(1);
      else                r_cnt <= r_cnt;
    end

    // Latched width result.
    always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN)     r_width <= {CNT_W{1'b0}};
      else if (w_latch) r_width <= r_cnt;
      else              r_width <= r_width;
    end

    // Dead-sensor timer: cleared on each latch, saturates at TIMEOUT.
    always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN)             r_to <= {TO_W{1'b0}};
      else if (w_latch)         r_to <= {TO_W{1'b0}};
      else if (r_to != TO_FULL) r_to <= r_to + TO_W'(1);
      else                      r_to <= r_to;
    end

    assign w_latch_v[gi]     = w_latch;
    assign w_sat_v[gi]       = w_sat;
    assign w_stale_set_v[gi] = ~w_latch & (r_to == TO_LAST);
    assign w_width[gi]       = r_width;

`ifdef PWM_AVG_EN
    logic [CNT_W-1:0] r_hist [4];
    logic [CNT_W-1:0] r_avg;
    logic             r_lat_d;
    logic [CNT_W+1:0] w_sum;

    assign w_sum = {2'b00, r_hist[0]} + {2'b00, r_hist[1]}
                 + {2'b00, r_hist[2]} + {2'b00, r_hist[3]};

    // Width history, shifted in alongside the WIDTH update.
    always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
        r_hist[0] <= {CNT_W{1'b0}};
        r_hist[1] <= {CNT_W{1'b0}};
        r_hist[2] <= {CNT_W{1'b0}};
        r_hist[3] <= {CNT_W{1'b0}};
      end else if (w_latch) begin
        r_hist[0] <= r_cnt;
        r_hist[1] <= r_hist[0];
        r_hist[2] <= r_hist[1];
        r_hist[3] <= r_hist[2];
      end else begin
        r_hist <= r_hist;
      end
    end

    // Average register, refreshed the cycle after the history shifts.
    always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
        r_lat_d <= 1'b0;
        r_avg   <= {CNT_W{1'b0}};
      end else begin
        r_lat_d <= w_latch;
        if (r_lat_d) r_avg <= w_sum[CNT_W+1:2];
        else         r_avg <= r_avg;
      end
    end

    assign w_avg[gi] = r_avg;
`else
    assign w_avg[gi] = {CNT_W{1'b0}};
`endif
  end

  // Pad result arrays to the 8 decodable channel slots.
  for (gi = 0; gi < 8; gi++) begin : g_rd
    if (gi < NUM_CH) begin : g_on
      assign w_width_rd[gi] = 32'(w_width[gi]);
      assign w_avg_rd[gi]   = 32'(w_avg[gi]);
    end else begin : g_off
      assign w_width_rd[gi] = 32'd0;
      assign w_avg_rd[gi]   = 32'd0;
    end
  end

  // Next values of control/status: hardware sets win over W1C clears.
  always_comb begin
    if (w_wr_status) begin
      w_new_nxt = r_new & ~PWDATA[NUM_CH-1:0];
      w_ovf_nxt = r_ovf & ~PWDATA[8 +: NUM_CH];
    end else begin
      w_new_nxt = r_new;
      w_ovf_nxt = r_ovf;
    end
    w_new_nxt   = w_new_nxt | w_latch_v;
    w_ovf_nxt   = w_ovf_nxt | w_sat_v;
    w_stale_nxt = (r_stale & ~w_latch_v) | w_stale_set_v;
    if (w_wr_ctrl)   w_en_nxt = PWDATA[NUM_CH-1:0];
    else             w_en_nxt = r_en;
    if (w_wr_irq_en) w_irq_en_nxt = PWDATA[NUM_CH-1:0];
    else             w_irq_en_nxt = r_irq_en;
  end

  // Control/status registers and registered interrupt (tracks NEW & IRQ_EN).
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_en     <= {NUM_CH{1'b1}};
      r_irq_en <= {NUM_CH{1'b0}};
      r_new    <= {NUM_CH{1'b0}};
      r_ovf    <= {NUM_CH{1'b0}};
      r_stale  <= {NUM_CH{1'b0}};
      r_irq    <= 1'b0;
    end else begin
      r_en     <= w_en_nxt;
      r_irq_en <= w_irq_en_nxt;
      r_new    <= w_new_nxt;
      r_ovf    <= w_ovf_nxt;
      r_stale  <= w_stale_nxt;
      r_irq    <= |(w_new_nxt & w_irq_en_nxt);
    end
  end

  // Combinational read decode.
  always_comb begin
    PRDATA = 32'd0;
    if (PSEL && !PWRITE) begin
      case (PADDR[7:5])
        3'b000: begin
          if (PADDR[1:0] == 2'b00) PRDATA = w_width_rd[PADDR[4:2]];
          else                     PRDATA = 32'd0;
        end
        3'b001: begin
          if (PADDR[1:0] == 2'b00) PRDATA = w_avg_rd[PADDR[4:2]];
          else                     PRDATA = 32'd0;
        end
        3'b010: begin
          case (PADDR[4:0])
            5'h00:   PRDATA = {8'd0, 8'(r_stale), 8'(r_ovf), 8'(r_new)};
            5'h04:   PRDATA = 32'(r_en);
            5'h08:   PRDATA = 32'(r_irq_en);
            default: PRDATA = 32'd0;
          endcase
        end
        default: PRDATA = 32'd0;
      endcase
    end else begin
      PRDATA = 32'd0;
    end
  end

endmodule
